// File: rtl/aes_sub_bytes_if.sv
// Valid/ready bus for the AES byte-substitution engine.
// The input side carries a beat of NUM_BYTES lanes plus its S-box mode.
// The output side returns the substituted beat together with that mode.
interface aes_sub_bytes_if #(
    parameter int NUM_BYTES = 16
);
    logic                   in_valid;
    logic                   in_ready;
    logic                   in_inverse;
    logic [8*NUM_BYTES-1:0] in_data;
    logic                   out_valid;
    logic                   out_ready;
    logic                   out_inverse;
    logic [8*NUM_BYTES-1:0] out_data;

    // Producer/consumer side: drives beats in and accepts results.
    modport master (
        output in_valid, in_inverse, in_data, out_ready,
        input  in_ready, out_valid, out_inverse, out_data
    );

    // Engine side.
    modport slave (
        input  in_valid, in_inverse, in_data, out_ready,
        output in_ready, out_valid, out_inverse, out_data
    );
endinterface

// File: rtl/aes_sub_bytes_pipe.sv
// Pipelined AES SubBytes / InvSubBytes engine.
// The S-box is computed arithmetically: a GF(2^8) inverse, built as x^254
// from a square-and-multiply chain, combined with the AES affine map. All
// substitution logic sits in front of slot 0. The remaining slots form an
// elastic register chain, which gives a fixed latency of PIPE_STAGES cycles
// and full throughput under a valid/ready handshake.
module aes_sub_bytes_pipe #(
    parameter int NUM_BYTES   = 16,
    parameter int PIPE_STAGES = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    aes_sub_bytes_if.slave       bus,
    output logic                 busy
);

    localparam int W = 8 * NUM_BYTES;

    typedef struct packed {
        logic         valid;
        logic         inverse;
        logic [W-1:0] data;
    } slot_t;

    // ---------------------------------------------------------------
    // GF(2^8) arithmetic modulo x^8 + x^4 + x^3 + x + 1
    // ---------------------------------------------------------------
    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] t;
        p = 8'h00;
        t = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ t;
            t = xtime(t);
        end
        return p;
    endfunction

    // x^254 == x^-1 for nonzero x. The chain also maps 0 to 0, as AES requires.
    function automatic logic [7:0] gf_inv(input logic [7:0] x);
        logic [7:0] x2, x3, x6, x12, x14, x15, x30, x60, x120, x240;
        x2   = gf_mul(x, x);
        x3   = gf_mul(x2, x);
        x6   = gf_mul(x3, x3);
        x12  = gf_mul(x6, x6);
        x14  = gf_mul(x12, x2);
        x15  = gf_mul(x12, x3);
        x30  = gf_mul(x15, x15);
        x60  = gf_mul(x30, x30);
        x120 = gf_mul(x60, x60);
        x240 = gf_mul(x120, x120);
        return gf_mul(x240, x14);
    endfunction

    function automatic logic [7:0] affine_fwd(input logic [7:0] x);
        return x ^ {x[6:0], x[7]} ^ {x[5:0], x[7:6]} ^ {x[4:0], x[7:5]}
                 ^ {x[3:0], x[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [7:0] affine_inv(input logic [7:0] x);
        return {x[6:0], x[7]} ^ {x[4:0], x[7:5]} ^ {x[1:0], x[7:2]} ^ 8'h05;
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] x, input logic inverse);
        return inverse ? gf_inv(affine_inv(x)) : affine_fwd(gf_inv(x));
    endfunction

    // ---------------------------------------------------------------
    // Datapath
    // ---------------------------------------------------------------
    logic [W-1:0]           sub_data;
    slot_t                  slot [PIPE_STAGES];
    slot_t                  feed [PIPE_STAGES];
    logic [PIPE_STAGES-1:0] en;
    logic [PIPE_STAGES-1:0] valid_vec;

    // Substitute every lane of the incoming beat under the beat's own mode.
    for (genvar i = 0; i < NUM_BYTES; i++) begin : g_lane
        assign sub_data[8*i +: 8] = sbox(bus.in_data[8*i +: 8], bus.in_inverse);
    end

    // Slot 0 loads the substituted input beat; each later slot loads its predecessor.
    assign feed[0] = {bus.in_valid, bus.in_inverse, sub_data};
    for (genvar k = 1; k < PIPE_STAGES; k++) begin : g_feed
        assign feed[k] = slot[k-1];
    end

    for (genvar k = 0; k < PIPE_STAGES; k++) begin : g_valid
        assign valid_vec[k] = slot[k].valid;
    end

    // A slot may load when out_ready is high or when any slot from it to the output is empty.
    always_comb begin : ready_chain
        logic full;
        // NOTE: every variable written here is given a value before any branch
        // or loop, so no path leaves it unassigned and no latch is inferred.
        full = 1'b1;
        en   = '0;
        for (int k = PIPE_STAGES - 1; k >= 0; k--) begin
            full  = full & slot[k].valid;
            en[k] = bus.out_ready | ~full;
        end
    end

    // Slot registers: cleared on reset, and otherwise advanced wherever the chain allows.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: the data fields are don't-care while a slot is empty. They are
            // still cleared, so that out_data reads as zero straight out of reset.
            for (int k = 0; k < PIPE_STAGES; k++) slot[k] <= '0;
        end else begin
            for (int k = 0; k < PIPE_STAGES; k++) begin
                // NOTE: non-blocking updates let every slot sample its
                // predecessor's old value, so the shift is race-free.
                if (en[k]) slot[k] <= feed[k];
            end
        end
    end

    assign bus.in_ready    = en[0];
    assign bus.out_valid   = slot[PIPE_STAGES-1].valid;
    assign bus.out_inverse = slot[PIPE_STAGES-1].inverse;
    assign bus.out_data    = slot[PIPE_STAGES-1].data;
    assign busy            = |valid_vec;

endmodule

// File: tb/tb_aes_sub_bytes_pipe.sv
// Directed bench for aes_sub_bytes_pipe. The main instance (16 lanes, 2 stages)
// takes the single-beat, backpressure, interleave and reset sequences. Two
// further instances (4 lanes/3 stages and 1 lane/1 stage) join the main one in
// an exhaustive forward and inverse sweep against the golden AES S-box.
module tb_aes_sub_bytes_pipe;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    aes_sub_bytes_if #(.NUM_BYTES(16)) bus16 ();
    aes_sub_bytes_if #(.NUM_BYTES(4))  bus4 ();
    aes_sub_bytes_if #(.NUM_BYTES(1))  bus1 ();
    logic busy16, busy4, busy1;

    aes_sub_bytes_pipe #(.NUM_BYTES(16), .PIPE_STAGES(2)) dut16 (
        .clk(clk), .rst_n(rst_n), .bus(bus16), .busy(busy16));
    aes_sub_bytes_pipe #(.NUM_BYTES(4), .PIPE_STAGES(3)) dut4 (
        .clk(clk), .rst_n(rst_n), .bus(bus4), .busy(busy4));
    aes_sub_bytes_pipe #(.NUM_BYTES(1), .PIPE_STAGES(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .bus(bus1), .busy(busy1));

    // Golden AES forward S-box; entry 0 occupies the most significant byte.
    localparam logic [2047:0] SBOX_HEX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    int tests = 0;
    int fails = 0;

    task automatic check(input string tag, input logic [127:0] observed,
                         input logic [127:0] expected);
        tests++;
        assert (observed === expected) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] gold(input int k);
        logic [2047:0] t;
        t = SBOX_HEX;
        return t[2047 - 8*k -: 8];
    endfunction

    function automatic logic [7:0] lane_val(input int c, input int stride, input int i);
        return 8'((c + stride * i) & 255);
    endfunction

    logic [7:0]   t1_in [16] = '{8'h00, 8'h01, 8'h53, 8'hFF, 8'h10, 8'h20, 8'h30, 8'h40,
                                 8'h50, 8'h60, 8'h70, 8'h80, 8'h90, 8'hA0, 8'hB0, 8'hC0};
    logic [7:0]   t1_ex [16] = '{8'h63, 8'h7C, 8'hED, 8'h16, 8'hCA, 8'hB7, 8'h04, 8'h09,
                                 8'h53, 8'hD0, 8'h51, 8'hCD, 8'h60, 8'hE0, 8'hE7, 8'hBA};
    logic [7:0]   t2_in [4]  = '{8'h00, 8'h63, 8'h16, 8'hED};
    logic [7:0]   t2_ex [4]  = '{8'h52, 8'h00, 8'hFF, 8'h53};
    logic [7:0]   bp_b  [5]  = '{8'h01, 8'h53, 8'hFF, 8'h10, 8'h20};
    logic [7:0]   bp_e  [5]  = '{8'h7C, 8'hED, 8'h16, 8'hCA, 8'hB7};
    logic [7:0]   il_b  [4]  = '{8'h53, 8'hED, 8'h00, 8'h00};
    logic [7:0]   il_e  [4]  = '{8'hED, 8'h53, 8'h63, 8'h52};
    logic [127:0] vin, vex;
    logic [127:0] q16 [$];
    logic [31:0]  q4  [$];
    logic [7:0]   q1  [$];
    logic [127:0] bpq [$];
    logic [31:0]  v4;
    int acc, noready;

    initial begin
        bus16.in_valid = 1'b0; bus16.in_inverse = 1'b0; bus16.in_data = '0; bus16.out_ready = 1'b1;
        bus4.in_valid  = 1'b0; bus4.in_inverse  = 1'b0; bus4.in_data  = '0; bus4.out_ready  = 1'b1;
        bus1.in_valid  = 1'b0; bus1.in_inverse  = 1'b0; bus1.in_data  = '0; bus1.out_ready  = 1'b1;

        // ---- reset state ----
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_out_valid",   bus16.out_valid, 0);
        check("rst_out_data",    bus16.out_data, 0);
        check("rst_out_inverse", bus16.out_inverse, 0);
        check("rst_busy",        busy16, 0);
        step(); rst_n = 1'b1;
        @(negedge clk);
        check("rst_in_ready", bus16.in_ready, 1);

        // ---- forward single beat, exact latency of 2 ----
        for (int i = 0; i < 16; i++) begin
            vin[8*i +: 8] = t1_in[i];
            vex[8*i +: 8] = t1_ex[i];
        end
        step(); bus16.in_valid = 1'b1; bus16.in_inverse = 1'b0; bus16.in_data = vin;
        @(negedge clk);
        check("fwd_in_ready", bus16.in_ready, 1);
        step(); bus16.in_valid = 1'b0;
        @(negedge clk);
        check("fwd_not_early", bus16.out_valid, 0);
        step();
        @(negedge clk);
        check("fwd_out_valid",   bus16.out_valid, 1);
        check("fwd_out_data",    bus16.out_data, vex);
        check("fwd_out_inverse", bus16.out_inverse, 0);
        step();
        @(negedge clk);
        check("fwd_single_beat", bus16.out_valid, 0);

        // ---- inverse single beat ----
        for (int i = 0; i < 16; i++) begin
            vin[8*i +: 8] = (i < 4) ? t2_in[i] : 8'h00;
            vex[8*i +: 8] = (i < 4) ? t2_ex[i] : 8'h52;
        end
        step(); bus16.in_valid = 1'b1; bus16.in_inverse = 1'b1; bus16.in_data = vin;
        @(negedge clk);
        step(); bus16.in_valid = 1'b0;
        step();
        @(negedge clk);
        check("inv_out_valid",   bus16.out_valid, 1);
        check("inv_out_data",    bus16.out_data, vex);
        check("inv_out_inverse", bus16.out_inverse, 1);

        // ---- backpressure: five beats offered with out_ready low ----
        step(); bus16.out_ready = 1'b0;
        acc = 0;
        for (int c = 0; c < 6; c++) begin
            if (c > 0) step();
            bus16.in_valid = 1'b1; bus16.in_inverse = 1'b0; bus16.in_data = {16{bp_b[acc]}};
            @(negedge clk);
            if (bus16.in_ready) acc++;
        end
        check("bp_accepted", acc, 2);
        check("bp_in_ready_low", bus16.in_ready, 0);
        check("bp_out_valid", bus16.out_valid, 1);
        check("bp_out_hold", bus16.out_data, {16{bp_e[0]}});
        step();
        @(negedge clk);
        check("bp_out_stable", bus16.out_data, {16{bp_e[0]}});
        check("bp_still_full", bus16.in_ready, 0);
        step(); bus16.out_ready = 1'b1;
        @(negedge clk);
        check("bp_release_ready", bus16.in_ready, 1);
        bpq.delete();
        for (int c = 0; c < 20; c++) begin
            if (c > 0) begin
                step();
                bus16.in_valid = (acc < 5);
                bus16.in_data  = {16{bp_b[(acc < 5) ? acc : 4]}};
                @(negedge clk);
            end
            if (bus16.out_valid) bpq.push_back(bus16.out_data);
            if (bus16.in_valid && bus16.in_ready) acc++;
        end
        check("bp_total_accepted", acc, 5);
        check("bp_total_out", bpq.size(), 5);
        for (int k = 0; k < 5; k++)
            check($sformatf("bp_order_%0d", k), (k < bpq.size()) ? bpq[k] : 'x, {16{bp_e[k]}});

        // ---- back-to-back forward/inverse interleave ----
        for (int c = 0; c < 8; c++) begin
            step();
            bus16.in_valid   = (c < 4);
            bus16.in_inverse = (c < 4) ? c[0] : 1'b0;
            bus16.in_data    = {16{il_b[(c < 4) ? c : 0]}};
            @(negedge clk);
            if (c < 4) check($sformatf("il_in_ready_%0d", c), bus16.in_ready, 1);
            if (c >= 2 && c < 6) begin
                check($sformatf("il_valid_%0d", c - 2), bus16.out_valid, 1);
                check($sformatf("il_data_%0d", c - 2), bus16.out_data, {16{il_e[c-2]}});
                check($sformatf("il_mode_%0d", c - 2), bus16.out_inverse, (c - 2) % 2);
            end
        end

        // ---- reset with two beats in flight ----
        step(); bus16.out_ready = 1'b0;
        bus16.in_valid = 1'b1; bus16.in_inverse = 1'b0; bus16.in_data = {16{8'h01}};
        step(); bus16.in_data = {16{8'h53}};
        step(); bus16.in_valid = 1'b0;
        @(negedge clk);
        check("mid_busy_before", busy16, 1);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_out_valid", bus16.out_valid, 0);
        check("mid_rst_busy", busy16, 0);
        step(); rst_n = 1'b1; bus16.out_ready = 1'b1;
        @(negedge clk);
        check("mid_rst_in_ready", bus16.in_ready, 1);
        for (int c = 0; c < 4; c++) begin
            step();
            @(negedge clk);
            check($sformatf("mid_no_stale_%0d", c), bus16.out_valid, 0);
        end

        // ---- exhaustive forward sweep, then inverse round trip, on all three ----
        for (int p = 0; p < 2; p++) begin
            q16.delete(); q4.delete(); q1.delete();
            noready = 0;
            for (int c = 0; c < 262; c++) begin
                step();
                bus16.in_valid = (c < 256); bus4.in_valid = (c < 256); bus1.in_valid = (c < 256);
                bus16.in_inverse = p[0]; bus4.in_inverse = p[0]; bus1.in_inverse = p[0];
                for (int i = 0; i < 16; i++)
                    bus16.in_data[8*i +: 8] = p[0] ? gold(lane_val(c, 16, i)) : lane_val(c, 16, i);
                for (int i = 0; i < 4; i++)
                    bus4.in_data[8*i +: 8] = p[0] ? gold(lane_val(c, 64, i)) : lane_val(c, 64, i);
                bus1.in_data = p[0] ? gold(lane_val(c, 0, 0)) : lane_val(c, 0, 0);
                @(negedge clk);
                if (c < 256 && !(bus16.in_ready && bus4.in_ready && bus1.in_ready)) noready++;
                if (bus16.out_valid) q16.push_back(bus16.out_data);
                if (bus4.out_valid)  q4.push_back(bus4.out_data);
                if (bus1.out_valid)  q1.push_back(bus1.out_data);
            end
            check($sformatf("sweep%0d_no_stall", p), noready, 0);
            check($sformatf("sweep%0d_count16", p), q16.size(), 256);
            check($sformatf("sweep%0d_count4", p), q4.size(), 256);
            check($sformatf("sweep%0d_count1", p), q1.size(), 256);
            for (int c = 0; c < 256; c++) begin
                for (int i = 0; i < 16; i++)
                    vex[8*i +: 8] = p[0] ? lane_val(c, 16, i) : gold(lane_val(c, 16, i));
                for (int i = 0; i < 4; i++)
                    v4[8*i +: 8] = p[0] ? lane_val(c, 64, i) : gold(lane_val(c, 64, i));
                check($sformatf("sweep%0d_n16_%0d", p, c), (c < q16.size()) ? q16[c] : 'x, vex);
                check($sformatf("sweep%0d_n4_%0d", p, c), (c < q4.size()) ? q4[c] : 'x, v4);
                check($sformatf("sweep%0d_n1_%0d", p, c), (c < q1.size()) ? q1[c] : 'x,
                      p[0] ? lane_val(c, 0, 0) : gold(c));
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
